// File: rtl/search_pipe_pkg.sv
// Shared types for the multi-channel signature search pipeline.
// Holds the engine state encoding and index-width helper.
package search_pipe_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        PUSH
    } state_t;

    // Index width that never collapses to zero for single-entry tables
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/search_fifo.sv
// Synchronous result FIFO; push is ignored when full, pop when empty.
// Head entry is presented combinationally on rdata.
module search_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp;
    logic [AW:0]  rp;

    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign rdata = mem[rp[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push && !full) begin
                mem[wp[AW-1:0]] <= wdata;
                wp <= wp + 1'b1;
            end
            if (pop && !empty) rp <= rp + 1'b1;
        end
    end

endmodule

// File: rtl/search_pipe_mc.sv
// Multi-channel frame signature extraction and shared key-table search.
// Define SEARCH_BEST_EN to report the closest in-tolerance key instead of the first.
module search_pipe_mc
    import search_pipe_pkg::*;
#(
    parameter int CH         = 2,
    parameter int PIX_W      = 8,
    parameter int CNT_W      = 16,
    parameter int KEYS       = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CH-1:0]             pix_valid,
    input  logic [CH*PIX_W-1:0]       pix_data,
    input  logic [CH-1:0]             pix_eof,
    input  logic [PIX_W-1:0]          thresh,
    input  logic [CNT_W-1:0]          tol,
    input  logic                      key_we,
    input  logic [idx_w(KEYS)-1:0]    key_addr,
    input  logic [CNT_W-1:0]          key_data,
    output logic                      eth_valid,
    input  logic                      eth_ready,
    output logic [idx_w(CH)+idx_w(KEYS)+CNT_W:0] eth_data,
    output logic [CH-1:0]             disp_hit,
    output logic [CH*CNT_W-1:0]       disp_sig,
    output logic [CNT_W-1:0]          drop_cnt
);

    localparam int CW = idx_w(CH);
    localparam int KW = idx_w(KEYS);

    typedef struct packed {
        logic [CW-1:0]    ch;
        logic             hit;
        logic [KW-1:0]    key_idx;
        logic [CNT_W-1:0] sig;
    } result_t;

    localparam int RW = $bits(result_t);

    logic [CH-1:0]    pend;
    logic [CH-1:0]    grant;
    logic [CH-1:0]    drop_ev;
    logic [CNT_W-1:0] pend_sig [CH];

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_upd;
        logic [CNT_W-1:0] sig_q;
        logic             pend_q;
        logic             above;
        logic             eof_ev;

        assign above  = pix_data[c*PIX_W +: PIX_W] > thresh;
        assign eof_ev = pix_valid[c] & pix_eof[c];

        always_comb begin
            cnt_upd = cnt;
            if (above && (cnt != '1)) cnt_upd = cnt + 1'b1;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt <= '0;
            end else if (pix_valid[c]) begin
                cnt <= pix_eof[c] ? '0 : cnt_upd;
            end
        end

        // A grant in the eof cycle frees the slot just in time for the new frame
        always_ff @(posedge clk) begin
            if (rst) begin
                pend_q <= 1'b0;
                sig_q  <= '0;
            end else if (eof_ev && (!pend_q || grant[c])) begin
                pend_q <= 1'b1;
                sig_q  <= cnt_upd;
            end else if (grant[c]) begin
                pend_q <= 1'b0;
            end
        end

        assign pend[c]     = pend_q;
        assign pend_sig[c] = sig_q;
        assign drop_ev[c]  = eof_ev & pend_q & ~grant[c];
    end

    logic [CNT_W-1:0] keys [KEYS];
    logic [KEYS-1:0]  key_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            key_valid <= '0;
        end else if (key_we && (int'(key_addr) < KEYS)) begin
            keys[key_addr]      <= key_data;
            key_valid[key_addr] <= 1'b1;
        end
    end

    state_t           state_q;
    state_t           state_d;
    logic [CW-1:0]    last_ch;
    logic [CW-1:0]    cur_ch;
    logic [CNT_W-1:0] cur_sig;
    logic [KW-1:0]    k_q;
    logic             hit_q;
    logic [KW-1:0]    kidx_q;
    logic             found;
    logic [CW-1:0]    sel;
    logic             push;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] key_k;
    logic [CNT_W-1:0] diff;
    logic             match;
    logic             take;
    logic [CNT_W-1:0] drop_nxt;
    logic [CNT_W:0]   drop_sum;
    result_t          res;

    // Round-robin search starts just after the last granted channel
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = 1; i <= CH; i++) begin
            int j;
            j = (int'(last_ch) + i) % CH;
            if (!found && pend[j]) begin
                found = 1'b1;
                sel   = CW'(j);
            end
        end
    end

    assign key_k = keys[k_q];
    assign diff  = (cur_sig >= key_k) ? cur_sig - key_k : key_k - cur_sig;
    assign match = key_valid[k_q] && (diff <= tol);

`ifdef SEARCH_BEST_EN
    logic [CNT_W-1:0] best_q;
    assign take = match && (!hit_q || (diff < best_q));
`else
    assign take = match && !hit_q;
`endif

    always_comb begin
        state_d = state_q;
        grant   = '0;
        push    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant[sel] = 1'b1;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                if (k_q == KW'(KEYS - 1)) state_d = PUSH;
            end
            PUSH: begin
                if (!full) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        drop_sum = {1'b0, drop_cnt} + (CNT_W+1)'($countones(drop_ev));
        drop_nxt = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_ch  <= CW'(CH - 1);
            cur_ch   <= '0;
            cur_sig  <= '0;
            k_q      <= '0;
            hit_q    <= 1'b0;
            kidx_q   <= '0;
            disp_hit <= '0;
            disp_sig <= '0;
            drop_cnt <= '0;
`ifdef SEARCH_BEST_EN
            best_q   <= '0;
`endif
        end else begin
            drop_cnt <= drop_nxt;
            if ((state_q == IDLE) && found) begin
                last_ch <= sel;
                cur_ch  <= sel;
                cur_sig <= pend_sig[sel];
                k_q     <= '0;
                hit_q   <= 1'b0;
                kidx_q  <= '0;
            end
            if (state_q == SCAN) begin
                k_q <= k_q + 1'b1;
                if (take) begin
                    hit_q  <= 1'b1;
                    kidx_q <= k_q;
`ifdef SEARCH_BEST_EN
                    best_q <= diff;
`endif
                end
            end
            if (push) begin
                disp_hit[cur_ch]                 <= hit_q;
                disp_sig[cur_ch*CNT_W +: CNT_W] <= cur_sig;
            end
        end
    end

    assign res = '{ch: cur_ch, hit: hit_q, key_idx: kidx_q, sig: cur_sig};

    search_fifo #(
        .W     (RW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (res),
        .pop   (eth_valid && eth_ready),
        .rdata (eth_data),
        .full  (full),
        .empty (empty)
    );

    assign eth_valid = !empty;

endmodule
